apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter_if.sv | 28 ++
 rtl/apb_req_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - APB bus bundle between the request arbiter and its completer
interface apb_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [2:0]        PPROT;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter funnelling NREQ requesters onto one APB master
module apb_req_arbiter #(
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    parameter int  NREQ    = 2,
    parameter int  TIMEOUT = 16,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   apb4_en,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    input  logic [NREQ*STRB_W-1:0] req_strb,
    input  logic [NREQ*3-1:0]      req_prot,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    apb_req_arbiter_if.master      apb
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic [CNT_W-1:0]  r_wait;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic [STRB_W-1:0] r_pstrb;
    logic [2:0]        r_pprot;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    int                w_idx;
    logic              w_any;
    logic [PTR_W-1:0]  w_gnt;
    logic [PTR_W-1:0]  w_next_ptr;
    logic [ADDR_W-1:0] w_addr;
    logic              w_write;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_strb;
    logic [2:0]        w_prot;
    logic              w_timeout;
    logic [NREQ-1:0]   w_owner_oh;

    // Rotating priority: the search starts at r_rr_ptr and wraps, first valid wins.
    always_comb begin
        w_idx      = 0;
        w_any      = 1'b0;
        w_gnt      = '0;
        w_next_ptr = '0;
        w_addr     = '0;
        w_write    = 1'b0;
        w_wdata    = '0;
        w_strb     = '0;
        w_prot     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any      = 1'b1;
                w_gnt      = PTR_W'(w_idx);
                w_next_ptr = PTR_W'((w_idx + 1) % NREQ);
                w_addr     = req_addr[w_idx*ADDR_W +: ADDR_W];
                w_write    = req_write[w_idx];
                w_wdata    = req_wdata[w_idx*DATA_W +: DATA_W];
                w_strb     = req_strb[w_idx*STRB_W +: STRB_W];
                w_prot     = req_prot[w_idx*3 +: 3];
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE && w_any) ? (NREQ'(1) << w_gnt) : '0;
    assign w_owner_oh = NREQ'(1) << r_owner;
    // r_wait counts ACCESS cycles already spent waiting; the last allowed one aborts.
    assign w_timeout  = (TIMEOUT != 0) && (r_wait == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_wait      <= '0;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_paddr   <= w_addr;
                        r_pwrite  <= w_write;
                        r_pwdata  <= w_wdata;
                        r_pstrb   <= (apb4_en && w_write) ? w_strb : '0;
                        r_pprot   <= apb4_en ? w_prot : 3'b000;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_owner   <= w_gnt;
                        r_rr_ptr  <= w_next_ptr;
                        r_wait    <= '0;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb.PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_rdata <= r_pwrite ? '0 : apb.PRDATA;
                        r_rsp_err   <= apb.PSLVERR;
                        r_state     <= S_IDLE;
                    end else if (w_timeout) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign apb.PADDR   = r_paddr;
    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_pwrite;
    assign apb.PWDATA  = r_pwdata;
    assign apb.PSTRB   = r_pstrb;
    assign apb.PPROT   = r_pprot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter with a transaction-level reference
module tb_apb_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int NR = 2;
    localparam int TO = 4;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic            apb4_en = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR*SW-1:0] req_strb = '0;
    logic [NR*3-1:0]  req_prot = '0;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;

    apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NREQ(NR), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb4_en(apb4_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb(apb.master)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; logic [SW-1:0] strb; logic [2:0] prot; int cyc; } apb_t;
    typedef struct { int owner; logic [DW-1:0] rdata; logic err; int cyc; } rsp_t;
    typedef struct { int n; logic [DW-1:0] rdata; logic err; } plan_t;

    apb_t  exp_apb[$];
    rsp_t  exp_rsp[$];
    plan_t plan_q[$];

    int errors = 0;
    int checks = 0;
    int ptr = 0;
    int busy_until = 0;
    int force_n = -1;
    logic [DW-1:0] force_rd = '0;
    logic force_err = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_req(input int i);
        req_write[i]           = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW]   = $urandom;
        req_wdata[i*DW +: DW]  = $urandom;
        req_strb[i*SW +: SW]   = SW'($urandom);
        req_prot[i*3 +: 3]     = 3'($urandom);
        req_valid[i]           = 1'b1;
    endtask

    task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] p, input int n,
                         input logic [DW-1:0] rd, input bit e);
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
        req_prot[i*3 +: 3]    = p;
        req_valid[i]          = 1'b1;
        force_n   = n;
        force_rd  = rd;
        force_err = e;
    endtask

    // Reference: an access is a whole transaction; the arbiter is free again on its response cycle.
    task automatic run_cycles(input int ncyc, input int issue_pct);
        for (int c = 0; c < ncyc; c++) begin
            logic [NR-1:0] exp_rdy;
            int g, n, lat, t;
            logic [DW-1:0] rd;
            logic e, wr, tmo;
            apb_t a;
            rsp_t r;
            plan_t p;
            @(negedge PCLK);
            t = cyc;
            exp_rdy = '0;
            g = -1;
            if (t >= busy_until) begin
                for (int k = 0; k < NR; k++)
                    if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
            end
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                if (force_n >= 0) begin
                    n = force_n; rd = force_rd; e = force_err; force_n = -1;
                end else begin
                    n = $urandom_range(0, 5); rd = $urandom; e = 1'($urandom_range(0, 1));
                end
                wr  = req_write[g];
                tmo = (n >= TO);
                lat = tmo ? TO - 1 : n;
                a.addr  = req_addr[g*AW +: AW];
                a.wr    = wr;
                a.wdata = req_wdata[g*DW +: DW];
                a.strb  = (apb4_en && wr) ? req_strb[g*SW +: SW] : '0;
                a.prot  = apb4_en ? req_prot[g*3 +: 3] : 3'b000;
                a.cyc   = t + 1;
                r.owner = g;
                r.rdata = (tmo || wr) ? '0 : rd;
                r.err   = tmo ? 1'b1 : e;
                r.cyc   = t + 3 + lat;
                p.n = n; p.rdata = rd; p.err = e;
                exp_apb.push_back(a);
                exp_rsp.push_back(r);
                plan_q.push_back(p);
                busy_until = t + 3 + lat;
                ptr = (g + 1) % NR;
            end
            check("req_ready", req_ready, exp_rdy);
            @(posedge PCLK);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (exp_rdy[i]) req_valid[i] = 1'b0;
                if (req_valid[i] && issue_pct > 0 && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 99) < issue_pct) new_req(i);
            end
        end
    endtask

    // APB completer: follows the plan chosen when the transfer was accepted.
    initial begin
        plan_t p;
        int acnt;
        p.n = 100; p.rdata = '0; p.err = 1'b0;
        acnt = 0;
        apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            apb.PRDATA  = $urandom;
            apb.PSLVERR = 1'($urandom_range(0, 1));
            apb.PREADY  = 1'($urandom_range(0, 1));
            if (PRESETn && apb.PSEL && !apb.PENABLE) begin
                if (plan_q.size() != 0) p = plan_q.pop_front();
                else p.n = 100;
                acnt = 0;
            end else if (PRESETn && apb.PSEL && apb.PENABLE) begin
                if (acnt == p.n) begin
                    apb.PREADY = 1'b1; apb.PRDATA = p.rdata; apb.PSLVERR = p.err;
                end else begin
                    apb.PREADY = 1'b0;
                end
                acnt++;
            end
        end
    end

    // Monitor: pops expected bus phases and responses as the DUT presents them.
    initial begin
        apb_t cur;
        rsp_t r;
        bit have;
        have = 1'b0;
        cur.addr = '0; cur.wr = 1'b0; cur.wdata = '0; cur.strb = '0; cur.prot = '0; cur.cyc = 0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                have = 1'b0;
                continue;
            end
            if (apb.PSEL && !apb.PENABLE) begin
                if (exp_apb.size() == 0) begin
                    check("unexpected_setup", apb.PSEL, 1'b0);
                end else begin
                    cur = exp_apb.pop_front();
                    have = 1'b1;
                    check("setup_cycle", cyc, cur.cyc);
                    check("setup_fields", {apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB, apb.PPROT},
                          {cur.addr, cur.wr, cur.wdata, cur.strb, cur.prot});
                end
            end else if (apb.PSEL && apb.PENABLE && have) begin
                check("access_hold", {apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB, apb.PPROT},
                      {cur.addr, cur.wr, cur.wdata, cur.strb, cur.prot});
            end
            if (rsp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    check("spurious_rsp", rsp_valid, '0);
                end else begin
                    logic [NR-1:0] oh;
                    r = exp_rsp.pop_front();
                    oh = '0;
                    oh[r.owner] = 1'b1;
                    check("rsp_cycle", cyc, r.cyc);
                    check("rsp_owner", rsp_valid, oh);
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_err", rsp_err, r.err);
                    check("rsp_psel_low", {apb.PSEL, apb.PENABLE}, 2'b00);
                end
            end else if (exp_rsp.size() != 0 && exp_rsp[0].cyc < cyc) begin
                logic [NR-1:0] oh;
                oh = '0;
                oh[exp_rsp[0].owner] = 1'b1;
                check("rsp_missing", rsp_valid, oh);
                void'(exp_rsp.pop_front());
            end
        end
    end

    initial begin
        @(negedge PCLK);
        check("reset_apb", {apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT, apb.PWRITE, apb.PSEL, apb.PENABLE}, '0);
        check("reset_rsp", {rsp_valid, rsp_rdata, rsp_err}, '0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;

        issue(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 3'b000, 0, 32'h0, 1'b0);
        run_cycles(8, 0);
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b010, 3, 32'h1234_5678, 1'b1);
        run_cycles(10, 0);
        issue(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, 9, 32'hDEAD_BEEF, 1'b0);
        run_cycles(12, 0);
        apb4_en = 1'b0;
        issue(1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'h3, 3'b101, 1, 32'h0, 1'b0);
        run_cycles(8, 0);

        apb4_en = 1'b1;
        run_cycles(400, 60);
        run_cycles(20, 0);
        apb4_en = 1'b0;
        run_cycles(200, 60);
        run_cycles(20, 0);
        apb4_en = 1'b1;

        issue(0, 1'b1, 32'h50, 32'h5555_AAAA, 4'hC, 3'b011, 9, 32'h0, 1'b0);
        run_cycles(3, 0);
        PRESETn = 1'b0;
        #1;
        check("midreset_apb", {apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT, apb.PWRITE, apb.PSEL, apb.PENABLE}, '0);
        check("midreset_rsp", rsp_valid, '0);
        exp_apb.delete();
        exp_rsp.delete();
        plan_q.delete();
        ptr = 0;
        busy_until = 0;
        force_n = -1;
        req_valid = '0;
        @(posedge PCLK);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        new_req(0);
        new_req(1);
        run_cycles(200, 90);
        run_cycles(20, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
